// File: rtl/ky32_stream_mux.sv
// N-channel valid/ready stream mux with a packet-locked grant and one registered output stage.
// Define KY32_MUX_RR_EN for round-robin arbitration; otherwise the lowest asserted index wins.
module ky32_stream_mux #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_last,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      sel_mode,
    input  logic [SEL_W-1:0]          sel,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_last,
    output logic [SEL_W-1:0]          out_chan,
    input  logic                      out_ready
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   grant_q, grant_d;
    logic               cand_valid;
    logic [SEL_W-1:0]   cand_idx;
    logic               sel_ok;
    logic [SEL_W-1:0]   sel_idx;
    logic               grant_valid;
    logic [SEL_W-1:0]   grant_idx;
    logic               load;
    logic               active;
    logic               xfer;
    logic               beat_last;
    logic [WIDTH-1:0]   beat_data;

`ifdef KY32_MUX_RR_EN
    logic [SEL_W-1:0]   rr_ptr_q;

    // Search starts at the pointer and wraps, so the channel after the last packet's owner is favoured.
    always_comb begin : arb_rr
        int idx;
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        idx        = 0;
        cand_valid = 1'b0;
        cand_idx   = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= CHANNELS) idx = idx - CHANNELS;
            if (!cand_valid && in_valid[idx]) begin
                cand_valid = 1'b1;
                cand_idx   = SEL_W'(idx);
            end
        end
    end
`else
    always_comb begin : arb_fixed
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        cand_valid = 1'b0;
        cand_idx   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!cand_valid && in_valid[i]) begin
                cand_valid = 1'b1;
                cand_idx   = SEL_W'(i);
            end
        end
    end
`endif

    // A single channel ignores sel entirely; otherwise indices past the last channel grant nothing.
    assign sel_ok  = (CHANNELS == 1) || (int'(sel) < CHANNELS);
    assign sel_idx = (CHANNELS == 1) ? '0 : sel;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (state_q == LOCKED) begin
            grant_valid = 1'b1;
            grant_idx   = grant_q;
        end else if (sel_mode) begin
            grant_valid = sel_ok;
            grant_idx   = sel_ok ? sel_idx : '0;
        end else begin
            grant_valid = cand_valid;
            grant_idx   = cand_idx;
        end
    end

    assign load      = !out_valid || out_ready;
    assign active    = rst_n && grant_valid && load;
    assign xfer      = active && in_valid[grant_idx];
    assign beat_last = in_last[grant_idx];
    assign beat_data = in_data[int'(grant_idx)*WIDTH +: WIDTH];

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            in_ready[i] = active && (grant_idx == SEL_W'(i));
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        if (xfer) begin
            if (beat_last) begin
                state_d = IDLE;
            end else begin
                state_d = LOCKED;
                grant_d = grant_idx;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    // Payload registers are reset as well so the output port reads as zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_chan  <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= beat_data;
            out_last  <= beat_last;
            out_chan  <= grant_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef KY32_MUX_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else if (xfer && beat_last) begin
            rr_ptr_q <= (int'(grant_idx) == CHANNELS - 1) ? '0 : grant_idx + SEL_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_ky32_stream_mux.sv
// Randomised and directed bench for ky32_stream_mux against a packet-level reference model.
// Five channels are used so that an out-of-range explicit select can actually be driven.
module tb_ky32_stream_mux;

    localparam int W  = 32;
    localparam int CH = 5;
    localparam int SW = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [CH-1:0]   in_valid;
    logic [CH*W-1:0] in_data;
    logic [CH-1:0]   in_last;
    logic [CH-1:0]   in_ready;
    logic            sel_mode;
    logic [SW-1:0]   sel;
    logic            out_valid;
    logic [W-1:0]    out_data;
    logic            out_last;
    logic [SW-1:0]   out_chan;
    logic            out_ready;

    ky32_stream_mux #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .sel_mode  (sel_mode),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_chan  (out_chan),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: packet owner (-1 when no packet open), RR pointer, and the output beat.
    int          m_owner;
    int          m_ptr;
    bit          m_ov;
    logic [W-1:0] m_od;
    bit          m_ol;
    int          m_oc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_ov    = 0;
        m_od    = '0;
        m_ol    = 0;
        m_oc    = 0;
    endtask

    function automatic int model_grant();
        if (!rst_n) return -1;
        if (m_owner >= 0) return m_owner;
        if (sel_mode) return (int'(sel) < CH) ? int'(sel) : -1;
`ifdef KY32_MUX_RR_EN
        for (int k = 0; k < CH; k++)
            if (in_valid[(m_ptr + k) % CH]) return (m_ptr + k) % CH;
`else
        for (int i = 0; i < CH; i++)
            if (in_valid[i]) return i;
`endif
        return -1;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, " out_valid"}, out_valid, m_ov);
        check({tag, " out_data"},  out_data,  m_od);
        check({tag, " out_last"},  out_last,  m_ol);
        check({tag, " out_chan"},  out_chan,  m_oc);
    endtask

    // One clock: check in_ready against the model, take the edge, then check the output register.
    task automatic step(input string tag);
        int           g;
        bit           xfer;
        logic [CH-1:0] exp_rdy;
        logic [W-1:0] d;
        bit           l;
        #2;
        g       = model_grant();
        exp_rdy = '0;
        if (g >= 0 && (!m_ov || out_ready)) exp_rdy[g] = 1'b1;
        check({tag, " in_ready"}, in_ready, exp_rdy);
        xfer = (exp_rdy != 0) && in_valid[g];
        d    = '0;
        l    = 0;
        if (xfer) begin
            d = in_data[g*W +: W];
            l = in_last[g];
        end
        @(posedge clk);
        if (xfer) begin
            m_ov = 1;
            m_od = d;
            m_ol = l;
            m_oc = g;
            if (l) begin
                m_owner = -1;
                m_ptr   = (g + 1) % CH;
            end else begin
                m_owner = g;
            end
        end else if (out_ready) begin
            m_ov = 0;
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic set_ch(input int i, input bit v, input logic [W-1:0] d, input bit l);
        in_valid[i]       = v;
        in_data[i*W +: W] = d;
        in_last[i]        = l;
    endtask

    task automatic idle_all();
        in_valid = '0;
        in_last  = '0;
    endtask

    initial begin
        in_valid  = '1;
        in_data   = '0;
        in_last   = '0;
        sel_mode  = 1'b0;
        sel       = '0;
        out_ready = 1'b1;
        model_reset();

        // Reset: outputs zero and no channel accepted even with every input valid.
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        check("reset in_ready", in_ready, '0);

        rst_n = 1'b1;
        idle_all();
        set_ch(2, 1, 32'hA5A5_A5A5, 1);
        step("single");
        check("single data", out_data, 32'hA5A5_A5A5);
        check("single chan", out_chan, 2);
        idle_all();
        step("single drain");

        // Packet lock: ch1 opens a packet, ch0 joins and must wait until ch1's last beat.
        set_ch(1, 1, 32'h1111_0001, 0);
        step("lock b0");
        set_ch(0, 1, 32'h0000_0099, 1);
        set_ch(1, 1, 32'h1111_0002, 0);
        step("lock b1");
        set_ch(1, 1, 32'h1111_0003, 1);
        step("lock b2");
        set_ch(1, 0, 32'h0, 0);
        step("lock ch0");
        check("lock ch0 served", out_chan, 0);
        idle_all();
        step("lock drain");

        // Arbitration among four valid single-beat channels.
        for (int i = 0; i < 4; i++) set_ch(i, 1, 32'h100 + i, 1);
        repeat (5) step("arb");
        idle_all();
        step("arb drain");

        // Explicit select, out-of-range select, and a select change inside a packet.
        sel_mode = 1'b1;
        for (int i = 0; i < CH; i++) set_ch(i, 1, 32'h200 + i, 1);
        sel = 3;
        step("sel3");
        sel = 5;
        step("sel oob");
        sel = 3;
        set_ch(3, 1, 32'h300, 0);
        step("sel pkt b0");
        sel = 0;
        set_ch(3, 1, 32'h301, 0);
        step("sel pkt b1");
        set_ch(3, 1, 32'h302, 1);
        step("sel pkt b2");
        step("sel after pkt");
        sel_mode = 1'b0;
        idle_all();
        step("sel drain");

        // Backpressure holds a beat, then reset lands in the middle of the packet.
        set_ch(4, 1, 32'hDEAD_0004, 0);
        step("bp b0");
        out_ready = 1'b0;
        set_ch(4, 1, 32'hBEEF_0004, 0);
        repeat (5) step("bp stall");
        out_ready = 1'b1;
        step("bp b1");
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("midreset");
        check("midreset in_ready", in_ready, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_all();
        set_ch(1, 1, 32'h0000_0077, 1);
        step("post reset");
        check("post reset chan", out_chan, 1);
        idle_all();
        step("post reset drain");

        // Random traffic with backpressure and occasional explicit selects.
        repeat (400) begin
            for (int i = 0; i < CH; i++)
                set_ch(i, ($urandom_range(0, 2) != 0), $urandom, ($urandom_range(0, 3) == 0));
            out_ready = ($urandom_range(0, 3) != 0);
            sel_mode  = ($urandom_range(0, 4) == 0);
            sel       = SW'($urandom_range(0, 7));
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
